seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller; successor to the fixed 4-digit scanner. Drives N_DIGITS common-select digits from a nibble-packed value, with a ready/valid write port, frame-synchronous double buffering (no tearing), per-digit decimal points, a sign digit, hex/decimal modes and PWM brightness. Sits between datapath status registers and board segment/select pins.

---
 rtl/seg_disp_pkg.sv | 54 +++++
 rtl/seg_decoder.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - segment glyph constants and nibble-to-glyph helper
//
// Purpose: shared 7-segment encodings for the scan controller.
// Glyph bits 0..6 = segments a..g, bit 7 = decimal point, all active-high.
// hex_to_seg() never sets the dp bit; the caller merges it.

package seg_disp_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Letters are only shown in hex mode; in decimal mode 10..15 are blank.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic hex_mode);
        logic [7:0] g;
        case (nibble)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: g = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: g = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: g = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: g = hex_mode ? SEG_E : SEG_BLANK;
            default: g = hex_mode ? SEG_F : SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational nibble/minus/dp to 8-bit glyph decoder
//
// Purpose: builds the active-high glyph for one digit slot.
// Ports:
//   nibble   in  4  digit value
//   hex_mode in  1  1: 10..15 as letters, 0: blank
//   minus    in  1  1: show minus glyph instead of the nibble
//   dp       in  1  decimal point
//   glyph    out 8  bit0..6 = a..g, bit7 = dp, active-high

module seg_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       minus,
    input  logic       dp,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = minus ? SEG_MINUS : hex_to_seg(nibble, hex_mode);
        glyph[SEG_DP_BIT] = dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed N-digit 7-segment scan controller
//
// Purpose: scans N_DIGITS common-select digits from a double-buffered,
// nibble-packed value with per-digit dp, sign digit and PWM brightness.
// Optional macro SEG_SCAN_LZB_EN: leading-zero blanking of the active value.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_valid/wr_ready write handshake into the pending buffer
//   wr_data           nibble i = digit i (digit 0 rightmost)
//   wr_dp, wr_neg     decimal points, minus on the most significant digit
//   brightness        PWM duty = brightness / 2^BRIGHT_W
//   seg               registered segments, bit7 = dp, polarity per SEG_ACTIVE_LOW
//   sel               registered one-hot digit select, polarity per SEL_ACTIVE_LOW
//   frame_done        one-cycle pulse after each frame wrap

module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIV_LOG2       = 14,
    parameter int BRIGHT_W       = 3,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*N_DIGITS-1:0]   wr_data,
    input  logic [N_DIGITS-1:0]     wr_dp,
    input  logic                    wr_neg,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     sel,
    output logic                    frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [DIV_LOG2-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  act_neg_q, act_neg_d, pend_neg_q, pend_neg_d;
    logic                  pend_full_q, pend_full_d;
    logic                  run_q, run_d;
    logic [7:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap, accept, swap;
    logic [3:0]            cur_nibble;
    logic                  cur_dp, cur_minus, cur_blank, lit;
    logic [7:0]            dec_glyph, glyph;
    logic [BRIGHT_W-1:0]   pwm_phase;

    // run_q keeps wr_ready low through reset and for the release cycle.
    assign wr_ready   = run_q && !pend_full_q;
    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

    assign tick   = &presc_q;
    assign wrap   = tick && (idx_q == LAST_IDX);
    assign accept = wr_valid && wr_ready;
    // accept and swap are exclusive: swap needs pend_full_q, which holds wr_ready low.
    assign swap   = wrap && pend_full_q;

    assign cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];
    assign cur_dp     = act_dp_q[idx_q];
    assign cur_minus  = act_neg_q && (idx_q == LAST_IDX);

`ifdef SEG_SCAN_LZB_EN
    logic [N_DIGITS-1:0] lead_zero;
    logic                zero_run;

    // lead_zero[i]: digit i and every higher digit are 0 with no dp.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (act_data_q[i*4 +: 4] == 4'h0) && !act_dp_q[i];
            lead_zero[i] = zero_run;
        end
    end

    assign cur_blank = lead_zero[idx_q] && (idx_q != '0) && !cur_minus;
`else
    assign cur_blank = 1'b0;
`endif

    seg_decoder u_dec (
        .nibble   (cur_nibble),
        .hex_mode (HEX_MODE != 0),
        .minus    (cur_minus),
        .dp       (cur_dp),
        .glyph    (dec_glyph)
    );

    assign glyph     = cur_blank ? {dec_glyph[SEG_DP_BIT], 7'b0} : dec_glyph;
    // PWM phase is the top bits of the slot prescaler, so each slot gets one period.
    assign pwm_phase = presc_q[DIV_LOG2-1 -: BRIGHT_W];
    assign lit       = pwm_phase < brightness;

    always_comb begin
        presc_d      = presc_q + DIV_LOG2'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        frame_done_d = wrap;
        run_d        = 1'b1;

        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_neg_d    = act_neg_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_neg_d   = pend_neg_q;
        pend_full_d  = pend_full_q;
        if (swap) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_neg_d   = pend_neg_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_data_d = wr_data;
            pend_dp_d   = wr_dp;
            pend_neg_d  = wr_neg;
            pend_full_d = 1'b1;
        end

        seg_d = (lit ? glyph : SEG_BLANK) ^ SEG_OFF;
        sel_d = (N_DIGITS'(1) << idx_q) ^ SEL_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_neg_q    <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_neg_q   <= 1'b0;
            pend_full_q  <= 1'b0;
            run_q        <= 1'b0;
            seg_q        <= SEG_OFF;
            sel_q        <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_neg_q    <= act_neg_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_neg_q   <= pend_neg_d;
            pend_full_q  <= pend_full_d;
            run_q        <= run_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
//
// Two instances share the inputs: u_a (hex mode, active-high pins) and
// u_b (decimal mode, inverted seg and sel pins). A cycle-count based model
// predicts both.

module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic        wr_neg = 1'b0;
    logic [1:0]  brightness = 2'd3;

    logic        a_ready, b_ready, a_fd, b_fd;
    logic [7:0]  a_seg, b_seg;
    logic [3:0]  a_sel, b_sel;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.N_DIGITS(4), .DIV_LOG2(4), .BRIGHT_W(2), .HEX_MODE(1),
                    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(a_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_neg(wr_neg), .brightness(brightness),
        .seg(a_seg), .sel(a_sel), .frame_done(a_fd));

    seg_scan_ctrl #(.N_DIGITS(4), .DIV_LOG2(4), .BRIGHT_W(2), .HEX_MODE(0),
                    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(b_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_neg(wr_neg), .brightness(brightness),
        .seg(b_seg), .sel(b_sel), .frame_done(b_fd));

    localparam logic [7:0] TBL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference state: cycles since reset release plus the two value buffers.
    int          cyc;
    bit          started;
    bit [15:0]   m_act_data, m_pend_data;
    bit [3:0]    m_act_dp, m_pend_dp;
    bit          m_act_neg, m_pend_neg, m_pend_full;
    logic [7:0]  ea_seg, eb_seg;
    logic [3:0]  ea_sel, eb_sel;
    logic        e_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_glyph(input int d, input bit hexm);
        logic [7:0] g;
        int nib;
        bit minus, allz;
        nib   = int'((m_act_data >> (4 * d)) & 16'hF);
        minus = m_act_neg && (d == 3);
        if (minus)                 g = 8'h40;
        else if (nib >= 10 && !hexm) g = 8'h00;
        else                       g = TBL[nib];
`ifdef SEG_SCAN_LZB_EN
        if (d > 0 && !minus) begin
            allz = 1'b1;
            for (int j = d; j < 4; j++)
                if (((m_act_data >> (4 * j)) & 16'hF) != 0 || m_act_dp[j]) allz = 1'b0;
            if (allz) g = 8'h00;
        end
`else
        allz = 1'b0;
`endif
        g[7] = m_act_dp[d];
        return g;
    endfunction

    // Predicts the outputs produced by the edge just taken, then advances the model.
    task automatic model_edge();
        int p, d;
        bit tick, lit, accept, swap;
        if (rst) begin
            cyc = 0; started = 0;
            m_act_data = '0; m_act_dp = '0; m_act_neg = 0;
            m_pend_data = '0; m_pend_dp = '0; m_pend_neg = 0; m_pend_full = 0;
            ea_seg = 8'h00; eb_seg = 8'hFF; ea_sel = 4'h0; eb_sel = 4'hF; e_fd = 0;
        end else begin
            p    = cyc % 16;
            d    = (cyc / 16) % 4;
            tick = (p == 15);
            lit  = (p / 4) < int'(brightness);
            ea_seg = lit ? ref_glyph(d, 1'b1) : 8'h00;
            eb_seg = ~(lit ? ref_glyph(d, 1'b0) : 8'h00);
            ea_sel = 4'(1 << d);
            eb_sel = ~ea_sel;
            e_fd   = tick && d == 3;
            accept = wr_valid && started && !m_pend_full;
            swap   = tick && d == 3 && m_pend_full;
            if (swap) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_neg = m_pend_neg;
                m_pend_full = 0;
            end else if (accept) begin
                m_pend_data = wr_data; m_pend_dp = wr_dp; m_pend_neg = wr_neg;
                m_pend_full = 1;
            end
            started = 1;
            cyc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("a_seg", 32'(a_seg), 32'(ea_seg));
        chk("b_seg", 32'(b_seg), 32'(eb_seg));
        chk("a_sel", 32'(a_sel), 32'(ea_sel));
        chk("b_sel", 32'(b_sel), 32'(eb_sel));
        chk("a_frame_done", 32'(a_fd), 32'(e_fd));
        chk("b_frame_done", 32'(b_fd), 32'(e_fd));
        chk("a_wr_ready", 32'(a_ready), 32'(started && !m_pend_full));
        chk("b_wr_ready", 32'(b_ready), 32'(started && !m_pend_full));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write1(input logic [15:0] data, input logic [3:0] dp, input logic neg);
        wr_valid = 1'b1; wr_data = data; wr_dp = dp; wr_neg = neg;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        // reset and idle scanning
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(200);

        // single hex write with dp, shown after the next wrap
        write1(16'h12AB, 4'b0100, 1'b0);
        run(140);

        // back-to-back writes with valid held: second stalls until the swap
        write1(16'h1111, 4'b0000, 1'b0);
        wr_valid = 1'b1; wr_data = 16'h2222;
        run(80);
        wr_valid = 1'b0;
        run(140);

        // sign digit, decimal mode blanks nibble C
        write1(16'h90C5, 4'b0000, 1'b1);
        run(140);

        // brightness sweep
        brightness = 2'd1; run(80);
        brightness = 2'd0; run(80);
        brightness = 2'd2; run(40);
        brightness = 2'd3;

        // leading-zero patterns
        write1(16'h0040, 4'b0000, 1'b0); run(140);
        write1(16'h0000, 4'b0000, 1'b0); run(140);
        write1(16'h0000, 4'b0010, 1'b1); run(140);

        // reset mid-frame with the pending buffer full
        write1(16'h5678, 4'b1111, 1'b0);
        run(5);
        rst = 1'b1; run(2);
        rst = 1'b0; run(140);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            wr_valid = ($urandom % 4) == 0;
            for (int n = 0; n < 4; n++)
                wr_data[n*4 +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom);
            for (int n = 0; n < 4; n++)
                wr_dp[n] = ($urandom % 8) == 0;
            wr_neg = ($urandom % 4) == 0;
            if (($urandom % 32) == 0) brightness = 2'($urandom);
            rst = ($urandom % 1500) == 0;
            step();
        end
        rst = 1'b0; wr_valid = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
